uxa_ps2_rx_ctrl: RTL

Receive sequencer for the UXA PS/2 keyboard port. It sits beside the PS/2 deserializing shift register and tracks PS/2 clock edges to find frame boundaries. At each boundary it captures the byte when framing is valid, then pulses the shift register's reset so the next frame starts clean. Captured bytes go into a small first-word-fall-through FIFO for the CPU I/O side; stalled frames are aborted by a watchdog.

---
 rtl/uxa_ps2_rx_ctrl_pkg.sv | 16 +
 rtl/uxa_ps2_rx_ctrl_if.sv | 27 ++
 rtl/uxa_ps2_rx_fifo.sv | 55 +++++
 rtl/uxa_ps2_rx_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uxa_ps2_rx_ctrl_pkg.sv
// Shared types and constants for the UXA PS/2 receive sequencer.
package uxa_ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam int FRAME_BITS      = 11;
    localparam int TIMEOUT_CYC_DEF = 100000;
    localparam int CHECK_DLY_DEF   = 3;
    localparam int FIFO_AW_DEF     = 3;

endpackage

// File: rtl/uxa_ps2_rx_ctrl_if.sv
// Bundle between the PS/2 receive sequencer, its shift register and the CPU I/O side.
interface uxa_ps2_rx_ctrl_if;

    logic       ps2_c_i;
    logic [7:0] d_i;
    logic       frame_i;
    logic       shfreg_rst_o;
    logic       rd_i;
    logic [7:0] dat_o;
    logic       empty_o;
    logic       ovf_o;
    logic       ferr_o;
    logic       tmo_o;
    logic       clr_i;
    logic       ps2_c_oe_o;

    modport slave (
        input  ps2_c_i, d_i, frame_i, rd_i, clr_i,
        output shfreg_rst_o, dat_o, empty_o, ovf_o, ferr_o, tmo_o, ps2_c_oe_o
    );

    modport master (
        output ps2_c_i, d_i, frame_i, rd_i, clr_i,
        input  shfreg_rst_o, dat_o, empty_o, ovf_o, ferr_o, tmo_o, ps2_c_oe_o
    );

endinterface

// File: rtl/uxa_ps2_rx_fifo.sv
// First-word-fall-through byte FIFO; a push when full is dropped unless a pop happens in the same cycle.
module uxa_ps2_rx_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wptr_r;
    logic [FIFO_AW-1:0] rptr_r;
    logic [FIFO_AW:0]   cnt_r;
    logic               pop_ok_s;
    logic               push_ok_s;

    assign empty     = (cnt_r == {(FIFO_AW+1){1'b0}});
    assign full      = (cnt_r == (FIFO_AW+1)'(DEPTH));
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rdata     = mem_r[rptr_r];

    // Storage, pointers and occupancy; memory is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wptr_r <= {FIFO_AW{1'b0}};
            rptr_r <= {FIFO_AW{1'b0}};
            cnt_r  <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wptr_r] <= wdata;
                wptr_r        <= wptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + {{FIFO_AW{1'b0}}, 1'b1};
                2'b01:   cnt_r <= cnt_r - {{FIFO_AW{1'b0}}, 1'b1};
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/uxa_ps2_rx_ctrl.sv
// PS/2 receive sequencer: frame tracking, capture, watchdog and byte FIFO.
// Optional clock inhibit while the FIFO is full: define UXA_PS2_INHIBIT_EN.
module uxa_ps2_rx_ctrl
    import uxa_ps2_pkg::*;
#(
    parameter int FIFO_AW     = FIFO_AW_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CHECK_DLY   = CHECK_DLY_DEF,
    parameter int CNT_W       = 17
) (
    input  logic               sys_clk_i,
    input  logic               reset_i,
    uxa_ps2_rx_ctrl_if.slave   bus
);

    state_t           state_r;
    logic [3:0]       edge_cnt_r;
    logic [CNT_W-1:0] wdog_r;
    logic [7:0]       dly_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             sync2_d_r;
    logic             rise_s;
    logic             shfreg_rst_r;
    logic             push_r;
    logic [7:0]       push_data_r;
    logic             ferr_r;
    logic             tmo_r;
    logic             ovf_r;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             drop_s;

    // Bring the asynchronous PS/2 clock into sys_clk and keep one delayed copy for edge detection.
    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            sync2_d_r <= 1'b1;
        end else begin
            sync1_r   <= bus.ps2_c_i;
            sync2_r   <= sync1_r;
            sync2_d_r <= sync2_r;
        end
    end

    assign rise_s = sync2_r & ~sync2_d_r;

    // Frame sequencer; the shift-register reset is high only during the single CLEAR cycle.
    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= ST_IDLE;
            edge_cnt_r   <= 4'd0;
            wdog_r       <= {CNT_W{1'b0}};
            dly_r        <= 8'd0;
            shfreg_rst_r <= 1'b1;
            push_r       <= 1'b0;
            push_data_r  <= 8'h00;
            ferr_r       <= 1'b0;
            tmo_r        <= 1'b0;
        end else begin
            shfreg_rst_r <= 1'b0;
            push_r       <= 1'b0;
            if (bus.clr_i) begin
                ferr_r <= 1'b0;
                tmo_r  <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        edge_cnt_r <= 4'd1;
                        wdog_r     <= {CNT_W{1'b0}};
                        state_r    <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (rise_s) begin
                        edge_cnt_r <= edge_cnt_r + 4'd1;
                        wdog_r     <= {CNT_W{1'b0}};
                        if (edge_cnt_r == 4'(FRAME_BITS - 1)) begin
                            dly_r   <= 8'(CHECK_DLY);
                            state_r <= ST_CHECK;
                        end
                    end else if (wdog_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                        tmo_r        <= 1'b1;
                        shfreg_rst_r <= 1'b1;
                        state_r      <= ST_CLEAR;
                    end else begin
                        wdog_r <= wdog_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_CHECK: begin
                    if (dly_r == 8'd0) begin
                        if (bus.frame_i) begin
                            push_r      <= 1'b1;
                            push_data_r <= bus.d_i;
                        end else begin
                            ferr_r <= 1'b1;
                        end
                        shfreg_rst_r <= 1'b1;
                        state_r      <= ST_CLEAR;
                    end else begin
                        dly_r <= dly_r - 8'd1;
                    end
                end
                ST_CLEAR: begin
                    edge_cnt_r <= 4'd0;
                    wdog_r     <= {CNT_W{1'b0}};
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    uxa_ps2_rx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rst   (reset_i),
        .push  (push_r),
        .wdata (push_data_r),
        .pop   (bus.rd_i),
        .rdata (bus.dat_o),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // A full FIFO only loses the byte when no pop frees a slot in the same cycle.
    assign drop_s = push_r && fifo_full_s && !bus.rd_i;

    // Sticky overflow; a new drop beats a simultaneous clear.
    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (bus.clr_i) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

`ifdef UXA_PS2_INHIBIT_EN
    logic ps2_c_oe_r;

    // Hold the device off between frames while there is no room for another byte.
    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            ps2_c_oe_r <= 1'b0;
        end else begin
            ps2_c_oe_r <= fifo_full_s && (state_r == ST_IDLE);
        end
    end

    assign bus.ps2_c_oe_o = ps2_c_oe_r;
`else
    assign bus.ps2_c_oe_o = 1'b0;
`endif

    assign bus.shfreg_rst_o = shfreg_rst_r;
    assign bus.empty_o      = fifo_empty_s;
    assign bus.ovf_o        = ovf_r;
    assign bus.ferr_o       = ferr_r;
    assign bus.tmo_o        = tmo_r;

endmodule
